reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1024, meaning idle cycles after which a held frequency lock is abandoned (valid range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports a_valid input 1, a_addr input 8, a_data input 8, a_ready output 1: write requester A (I2C slave side).
REQ-005 SHALL have ports b_valid input 1, b_addr input 8, b_data input 8, b_ready output 1: write requester B (internal sequencer).
REQ-006 SHALL have port reg_control  output  8  committed control register (map 0x00).
REQ-007 SHALL have port reg_freq  output  24  committed frequency word (low/mid/high bytes at map 0x02/0x03/0x04).
REQ-008 SHALL have port reg_duty  output  8  committed duty register (map 0x05).
REQ-009 SHALL have ports freq_commit, addr_err, lock_timeout  output  1 each  single-cycle event pulses.

Function
REQ-010 Transfer on a requester occurs in a cycle where x_valid and x_ready are both high; x_ready is combinational from valid inputs and arbiter state; at most one transfer per cycle.
REQ-011 Registered outputs update on the clock edge ending the transfer cycle (latency 1).
REQ-012 Writes to 0x00 or 0x05 update reg_control or reg_duty directly.
REQ-013 Writes to 0x02/0x03 go to a 24-bit shadow only; reg_freq is unchanged.
REQ-014 A write to 0x04 loads reg_freq = {data, shadow[15:8], shadow[7:0]} atomically and pulses freq_commit for one cycle.
REQ-015 Writes to any other address are accepted, discarded, and pulse addr_err for one cycle; no register changes.
REQ-016 FSM states: UNLOCKED, LOCK_A, LOCK_B.
REQ-017 UNLOCKED -> LOCK_x when x transfers to 0x02 or 0x03; the shadow is first loaded with reg_freq, then the written byte is applied.
REQ-018 UNLOCKED: a transfer to 0x04 commits using shadow = current reg_freq and stays UNLOCKED.
REQ-019 LOCK_x -> UNLOCKED when x transfers to 0x04 (commit per REQ-014).
REQ-020 In LOCK_x, the non-holder's ready is low for addresses 0x02..0x04; its other addresses remain arbitrable.
REQ-021 Arbitration when both eligible: round-robin; grant the requester not granted last; last-grant flag resets to B, so A wins first contention.
REQ-022 With a single eligible requester, it is granted regardless of the last-grant flag.
REQ-023 A 16-bit idle counter runs in LOCK_x and clears on every holder transfer.
REQ-024 When the counter reaches LOCK_TIMEOUT-1 with no holder transfer: go UNLOCKED, discard shadow, leave reg_freq unchanged, pulse lock_timeout.
REQ-025 If a holder transfer coincides with expiry, the transfer wins: lock retained (or released if 0x04) and the counter cleared; no lock_timeout pulse.
REQ-026 The counter is held at 0 in UNLOCKED.

Reset
REQ-027 On rst high at a clock edge: reg_control=0x1C, reg_freq=0x000000, reg_duty=0x80, shadow=0, state=UNLOCKED, counter=0, last-grant=B; all pulses low.
REQ-028 Reset mid-lock discards the shadow with no commit; a_ready/b_ready are low while rst is high.

Verification
REQ-029 A writes 0x02=0x34, 0x03=0x12, 0x04=0x00 -> reg_freq stays 0 until 0x04; then 0x001234 with one freq_commit pulse.
REQ-030 A and B both valid to 0x00 after reset -> A granted first (reg_control=A data); B granted next cycle; final reg_control = B data.
REQ-031 A writes 0x02 (LOCK_A); B requests 0x03 -> b_ready low; B then requests 0x05=0x40 -> accepted, reg_duty=0x40; lock stays LOCK_A.
REQ-032 LOCK_TIMEOUT=4: A writes 0x02=0xFF, then idles 4 cycles -> lock_timeout pulses once, state UNLOCKED, reg_freq unchanged; B 0x04 write then commits {data, old mid, old low}.
REQ-033 B writes 0x07 -> addr_err pulse, all registers unchanged; reg_freq=0x00AABB, A writes only 0x04=0x01 -> reg_freq=0x01AABB, freq_commit, no lock.
REQ-034 Assert rst while LOCK_B holds shadow 0x0000CC -> all outputs at REQ-027 values; a subsequent 0x04=0x02 commits 0x020000.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register write arbiter with locked 24-bit frequency word
//
// Ports:
//   clk, rst                    clock (rising edge) and synchronous active-high reset
//   a_valid/a_addr/a_data/a_ready   write requester A (I2C slave side)
//   b_valid/b_addr/b_data/b_ready   write requester B (internal sequencer)
//   reg_control, reg_freq, reg_duty committed registers (map 0x00, 0x02..0x04, 0x05)
//   freq_commit, addr_err, lock_timeout  single-cycle event pulses
module reg_write_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [7:0]  a_addr,
    input  logic [7:0]  a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [7:0]  b_addr,
    input  logic [7:0]  b_data,
    output logic        b_ready,
    output logic [7:0]  reg_control,
    output logic [23:0] reg_freq,
    output logic [7:0]  reg_duty,
    output logic        freq_commit,
    output logic        addr_err,
    output logic        lock_timeout
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK_A   = 2'd1,
        LOCK_B   = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

    state_t      state_q;
    logic [23:0] shadow_q;
    logic [15:0] idle_q;
    logic        last_a_q;      // 1 when A received the most recent grant
    logic [7:0]  control_q;
    logic [23:0] freq_q;
    logic [7:0]  duty_q;
    logic        freq_commit_q;
    logic        addr_err_q;
    logic        lock_timeout_q;

    logic        a_freq_addr;
    logic        b_freq_addr;
    logic        a_elig;
    logic        b_elig;
    logic        grant_a;
    logic        grant_b;
    logic        xfer;
    logic [7:0]  x_addr;
    logic [7:0]  x_data;
    logic        holder_xfer;
    logic        expire;
    logic [23:0] base_shadow;

    assign a_freq_addr = (a_addr >= 8'h02) && (a_addr <= 8'h04);
    assign b_freq_addr = (b_addr >= 8'h02) && (b_addr <= 8'h04);

    // The non-holder is shut out of the frequency bytes only; other addresses stay open.
    assign a_elig = a_valid && !((state_q == LOCK_B) && a_freq_addr);
    assign b_elig = b_valid && !((state_q == LOCK_A) && b_freq_addr);

    // Round-robin on contention, otherwise the lone eligible requester wins.
    assign grant_a = !rst && a_elig && (!b_elig || !last_a_q);
    assign grant_b = !rst && b_elig && (!a_elig ||  last_a_q);

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign xfer   = grant_a || grant_b;
    assign x_addr = grant_a ? a_addr : b_addr;
    assign x_data = grant_a ? a_data : b_data;

    assign holder_xfer = ((state_q == LOCK_A) && grant_a) || ((state_q == LOCK_B) && grant_b);
    assign expire      = (state_q != UNLOCKED) && !holder_xfer && (idle_q == TIMEOUT_LAST);

    // An unlocked write starts from the committed word so untouched bytes keep their value.
    assign base_shadow = (state_q == UNLOCKED) ? freq_q : shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= UNLOCKED;
            shadow_q       <= 24'h000000;
            idle_q         <= 16'h0000;
            last_a_q       <= 1'b0;
            control_q      <= 8'h1C;
            freq_q         <= 24'h000000;
            duty_q         <= 8'h80;
            freq_commit_q  <= 1'b0;
            addr_err_q     <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            freq_commit_q  <= 1'b0;
            addr_err_q     <= 1'b0;
            lock_timeout_q <= 1'b0;

            if (xfer) begin
                last_a_q <= grant_a;
                case (x_addr)
                    8'h00: control_q <= x_data;
                    8'h05: duty_q    <= x_data;
                    8'h02: begin
                        shadow_q <= {base_shadow[23:8], x_data};
                        if (state_q == UNLOCKED) begin
                            state_q <= grant_a ? LOCK_A : LOCK_B;
                        end
                    end
                    8'h03: begin
                        shadow_q <= {base_shadow[23:16], x_data, base_shadow[7:0]};
                        if (state_q == UNLOCKED) begin
                            state_q <= grant_a ? LOCK_A : LOCK_B;
                        end
                    end
                    8'h04: begin
                        // Only the holder (or anyone while unlocked) can reach 0x04 here.
                        freq_q        <= {x_data, base_shadow[15:0]};
                        freq_commit_q <= 1'b1;
                        state_q       <= UNLOCKED;
                    end
                    default: addr_err_q <= 1'b1;
                endcase
            end

            // Non-holder transfers never touch state or shadow, so expiry cannot collide with them.
            if ((state_q == UNLOCKED) || holder_xfer) begin
                idle_q <= 16'h0000;
            end else if (expire) begin
                idle_q         <= 16'h0000;
                state_q        <= UNLOCKED;
                shadow_q       <= 24'h000000;
                lock_timeout_q <= 1'b1;
            end else begin
                idle_q <= idle_q + 16'h0001;
            end
        end
    end

    assign reg_control  = control_q;
    assign reg_freq     = freq_q;
    assign reg_duty     = duty_q;
    assign freq_commit  = freq_commit_q;
    assign addr_err     = addr_err_q;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [7:0]  a_addr, a_data, b_addr, b_data;
    logic        a_ready, b_ready;
    logic [7:0]  reg_control, reg_duty;
    logic [23:0] reg_freq;
    logic        freq_commit, addr_err, lock_timeout;

    reg_write_arbiter #(.LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .reg_control(reg_control), .reg_freq(reg_freq), .reg_duty(reg_duty),
        .freq_commit(freq_commit), .addr_err(addr_err), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    typedef struct {
        logic       av; logic [7:0] aa; logic [7:0] ad;
        logic       bv; logic [7:0] ba; logic [7:0] bd;
        logic       ar; logic br;
        logic [7:0] ctrl; logic [23:0] freq; logic [7:0] duty;
        logic       fc; logic ae; logic lt;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [7:0] aa, input logic [7:0] ad,
                                input logic bv, input logic [7:0] ba, input logic [7:0] bd,
                                input logic ar, input logic br, input logic [7:0] ctrl,
                                input logic [23:0] freq, input logic [7:0] duty,
                                input logic fc, input logic ae, input logic lt);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ar = ar; v.br = br; v.ctrl = ctrl; v.freq = freq; v.duty = duty;
        v.fc = fc; v.ae = ae; v.lt = lt;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [7:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [7:0] ba, input logic [7:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] ctrl, input logic [23:0] freq,
                              input logic [7:0] duty, input logic fc, input logic ae, input logic lt);
        check({tag, " reg_control"}, 32'(reg_control), 32'(ctrl));
        check({tag, " reg_freq"}, 32'(reg_freq), 32'(freq));
        check({tag, " reg_duty"}, 32'(reg_duty), 32'(duty));
        check({tag, " freq_commit"}, 32'(freq_commit), 32'(fc));
        check({tag, " addr_err"}, 32'(addr_err), 32'(ae));
        check({tag, " lock_timeout"}, 32'(lock_timeout), 32'(lt));
    endtask

    // Reference model: owner 0 = nobody, 1 = A, 2 = B; idle counts consecutive lock cycles
    // without a holder write and the lock is dropped once it reaches LOCK_TIMEOUT.
    logic [7:0]  m_ctrl, m_duty;
    logic [23:0] m_freq, m_shadow;
    int          m_owner, m_idle;
    bit          m_last_a;
    logic        m_fc, m_ae, m_lt;

    task automatic model_reset();
        m_ctrl = 8'h1C; m_freq = 24'h0; m_duty = 8'h80; m_shadow = 24'h0;
        m_owner = 0; m_idle = 0; m_last_a = 1'b0; m_fc = 0; m_ae = 0; m_lt = 0;
    endtask

    task automatic model_ready(output logic ra, output logic rb);
        bit a_ok, b_ok;
        a_ok = a_valid && !(m_owner == 2 && a_addr >= 2 && a_addr <= 4);
        b_ok = b_valid && !(m_owner == 1 && b_addr >= 2 && b_addr <= 4);
        if (a_ok && b_ok) begin ra = !m_last_a; rb = m_last_a; end
        else begin ra = a_ok; rb = b_ok; end
    endtask

    task automatic model_step(input logic ra, input logic rb);
        int who, prev;
        logic [7:0] ad, dd;
        bit holder;
        prev = m_owner;
        m_fc = 0; m_ae = 0; m_lt = 0;
        who = ra ? 1 : 2;
        holder = (prev != 0) && (prev == who) && (ra || rb);
        if (ra || rb) begin
            ad = ra ? a_addr : b_addr;
            dd = ra ? a_data : b_data;
            m_last_a = ra;
            if (ad == 0) m_ctrl = dd;
            else if (ad == 5) m_duty = dd;
            else if (ad == 2 || ad == 3) begin
                if (m_owner == 0) begin m_shadow = m_freq; m_owner = who; end
                if (ad == 2) m_shadow[7:0] = dd; else m_shadow[15:8] = dd;
            end else if (ad == 4) begin
                if (m_owner == 0) m_shadow = m_freq;
                m_freq = {dd, m_shadow[15:0]};
                m_fc = 1;
                m_owner = 0;
            end else m_ae = 1;
        end
        if (prev == 0 || holder) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TO) begin
                m_owner = 0; m_idle = 0; m_shadow = 24'h0; m_lt = 1;
            end
        end
    endtask

    vec_t tbl[$];
    logic er, eb;

    initial begin
        rst = 1'b1;
        drive(1, 8'h00, 8'h11, 1, 8'h00, 8'h22);
        @(posedge clk); #1;
        #3;
        check("ready_a in reset", 32'(a_ready), 32'h0);
        check("ready_b in reset", 32'(b_ready), 32'h0);
        @(posedge clk); #1;
        check_outs("reset", 8'h1C, 24'h0, 8'h80, 0, 0, 0);
        rst = 1'b0;

        tbl.push_back(mk(1,8'h00,8'h11, 1,8'h00,8'h22, 1,0, 8'h11,24'h000000,8'h80, 0,0,0));
        tbl.push_back(mk(1,8'h00,8'h11, 1,8'h00,8'h22, 0,1, 8'h22,24'h000000,8'h80, 0,0,0));
        tbl.push_back(mk(1,8'h02,8'h34, 0,8'h00,8'h00, 1,0, 8'h22,24'h000000,8'h80, 0,0,0));
        tbl.push_back(mk(1,8'h03,8'h12, 0,8'h00,8'h00, 1,0, 8'h22,24'h000000,8'h80, 0,0,0));
        tbl.push_back(mk(1,8'h04,8'h00, 0,8'h00,8'h00, 1,0, 8'h22,24'h001234,8'h80, 1,0,0));
        tbl.push_back(mk(1,8'h02,8'h56, 0,8'h00,8'h00, 1,0, 8'h22,24'h001234,8'h80, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 1,8'h03,8'h99, 0,0, 8'h22,24'h001234,8'h80, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 1,8'h05,8'h40, 0,1, 8'h22,24'h001234,8'h40, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 1,8'h04,8'h77, 0,0, 8'h22,24'h001234,8'h40, 0,0,0));
        tbl.push_back(mk(1,8'h04,8'hAB, 1,8'h04,8'h77, 1,0, 8'h22,24'hAB1256,8'h40, 1,0,0));
        tbl.push_back(mk(1,8'h02,8'hFF, 0,8'h00,8'h00, 1,0, 8'h22,24'hAB1256,8'h40, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 0,8'h00,8'h00, 0,0, 8'h22,24'hAB1256,8'h40, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 0,8'h00,8'h00, 0,0, 8'h22,24'hAB1256,8'h40, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 0,8'h00,8'h00, 0,0, 8'h22,24'hAB1256,8'h40, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 0,8'h00,8'h00, 0,0, 8'h22,24'hAB1256,8'h40, 0,0,1));
        tbl.push_back(mk(0,8'h00,8'h00, 1,8'h04,8'hC3, 0,1, 8'h22,24'hC31256,8'h40, 1,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 1,8'h07,8'hEE, 0,1, 8'h22,24'hC31256,8'h40, 0,1,0));
        tbl.push_back(mk(1,8'h01,8'h55, 0,8'h00,8'h00, 1,0, 8'h22,24'hC31256,8'h40, 0,1,0));
        tbl.push_back(mk(1,8'h02,8'hBB, 0,8'h00,8'h00, 1,0, 8'h22,24'hC31256,8'h40, 0,0,0));
        tbl.push_back(mk(1,8'h03,8'hAA, 0,8'h00,8'h00, 1,0, 8'h22,24'hC31256,8'h40, 0,0,0));
        tbl.push_back(mk(1,8'h04,8'h00, 0,8'h00,8'h00, 1,0, 8'h22,24'h00AABB,8'h40, 1,0,0));
        tbl.push_back(mk(1,8'h04,8'h01, 0,8'h00,8'h00, 1,0, 8'h22,24'h01AABB,8'h40, 1,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 1,8'h02,8'h11, 0,1, 8'h22,24'h01AABB,8'h40, 0,0,0));
        tbl.push_back(mk(1,8'h02,8'h77, 0,8'h00,8'h00, 0,0, 8'h22,24'h01AABB,8'h40, 0,0,0));
        tbl.push_back(mk(1,8'h00,8'h5A, 1,8'h05,8'h66, 1,0, 8'h5A,24'h01AABB,8'h40, 0,0,0));
        tbl.push_back(mk(1,8'h00,8'h5A, 1,8'h05,8'h66, 0,1, 8'h5A,24'h01AABB,8'h66, 0,0,0));
        tbl.push_back(mk(0,8'h00,8'h00, 1,8'h04,8'h01, 0,1, 8'h5A,24'h01AA11,8'h66, 1,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
            #3;
            check($sformatf("vec%0d a_ready", i), 32'(a_ready), 32'(tbl[i].ar));
            check($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(tbl[i].br));
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].freq, tbl[i].duty,
                       tbl[i].fc, tbl[i].ae, tbl[i].lt);
        end

        // Reset in the middle of a B lock must drop the shadow without committing.
        rst = 1'b1; drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 8'h00, 8'h00, 1, 8'h02, 8'hCC);
        @(posedge clk); #1;
        drive(1, 8'h04, 8'h09, 1, 8'h04, 8'h09);
        rst = 1'b1;
        #3;
        check("mid-lock rst a_ready", 32'(a_ready), 32'h0);
        check("mid-lock rst b_ready", 32'(b_ready), 32'h0);
        @(posedge clk); #1;
        check_outs("mid-lock rst", 8'h1C, 24'h0, 8'h80, 0, 0, 0);
        rst = 1'b0;
        drive(1, 8'h04, 8'h02, 0, 8'h00, 8'h00);
        #3;
        check("post-rst a_ready", 32'(a_ready), 32'h1);
        @(posedge clk); #1;
        check_outs("post-rst commit", 8'h1C, 24'h020000, 8'h80, 1, 0, 0);

        // Randomized traffic against the reference model.
        rst = 1'b1; drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 6, 8'($urandom_range(0, 7)), 8'($urandom),
                  $urandom_range(0, 9) < 6, 8'($urandom_range(0, 7)), 8'($urandom));
            if ($urandom_range(0, 19) == 0) a_addr = 8'($urandom);
            #3;
            if (rst) begin er = 0; eb = 0; end
            else model_ready(er, eb);
            check("rand a_ready", 32'(a_ready), 32'(er));
            check("rand b_ready", 32'(b_ready), 32'(eb));
            @(posedge clk); #1;
            if (rst) model_reset();
            else model_step(er, eb);
            check_outs("rand", m_ctrl, m_freq, m_duty, m_fc, m_ae, m_lt);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
